sdram_arbit: RTL and testbench

Arbiter that owns the SDRAM command/address pins and shares them between the init, auto-refresh, write and read sub-modules. After power-up initialisation it grants the bus to one requester at a time: refresh first, then write/read. Each client's command, address and bank outputs are multiplexed onto the pins while that client holds the grant. It sits between the sub-modules and the SDRAM top-level pads.

---
 rtl/sdram_arbit.sv | 165 ++++++++++++++++
 tb/tb_sdram_arbit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sdram_arbit                                                   |
// | Purpose  : Shares the SDRAM command/address pins between the init,       |
// |            auto-refresh, write and read engines (refresh has priority).  |
// | Options  : SDRAM_ARBIT_RR_EN - round-robin between write and read        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sdram_arbit #(
  parameter int         ADDR_W  = 13,
  parameter int         BANK_W  = 2,
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [BANK_W-1:0] init_bank,
  input  logic              aref_req,
  output logic              aref_ack,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic              write_req,
  output logic              write_ack,
  input  logic              write_prech_end,
  input  logic [3:0]        write_cmd,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [BANK_W-1:0] write_bank,
  input  logic              read_req,
  output logic              read_ack,
  input  logic              read_prech_end,
  input  logic [3:0]        read_cmd,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [BANK_W-1:0] read_bank,
  output logic              refresh_pend,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_ba
);

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_aref_grant;
  logic              w_write_grant;
  logic              w_read_grant;
  logic              w_write_wins;
  logic [3:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [BANK_W-1:0] w_ba;
  logic              r_aref_ack;
  logic              r_write_ack;
  logic              r_read_ack;
  logic              r_refresh_pend;

`ifdef SDRAM_ARBIT_RR_EN
  // 1 = read was served last, so write goes first out of reset
  logic r_last_grant_rd;

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant_rd <= 1'b1;
    end else if (w_write_grant) begin
      r_last_grant_rd <= 1'b0;
    end else if (w_read_grant) begin
      r_last_grant_rd <= 1'b1;
    end
  end

  assign w_write_wins = write_req & (~read_req | r_last_grant_rd);
`else
  assign w_write_wins = write_req;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_aref_grant  = 1'b0;
    w_write_grant = 1'b0;
    w_read_grant  = 1'b0;
    w_cmd         = CMD_NOP;
    w_addr        = '0;
    w_ba          = '0;
    case (r_state)
      S_INIT: begin
        w_cmd  = init_cmd;
        w_addr = init_addr;
        w_ba   = init_bank;
        if (init_end) w_state_nxt = S_ARBIT;
      end
      S_ARBIT: begin
        if (aref_req) begin
          w_aref_grant = 1'b1;
          w_state_nxt  = S_AREF;
        end else if (w_write_wins) begin
          w_write_grant = 1'b1;
          w_state_nxt   = S_WRITE;
        end else if (read_req) begin
          w_read_grant = 1'b1;
          w_state_nxt  = S_READ;
        end
      end
      S_AREF: begin
        w_cmd  = aref_cmd;
        w_addr = aref_addr;
        w_ba   = aref_bank;
        if (aref_end) w_state_nxt = S_ARBIT;
      end
      S_WRITE: begin
        w_cmd  = write_cmd;
        w_addr = write_addr;
        w_ba   = write_bank;
        if (write_prech_end) w_state_nxt = S_ARBIT;
      end
      S_READ: begin
        w_cmd  = read_cmd;
        w_addr = read_addr;
        w_ba   = read_bank;
        if (read_prech_end) w_state_nxt = S_ARBIT;
      end
      default: w_state_nxt = S_ARBIT;
    endcase
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_INIT;
      r_aref_ack     <= 1'b0;
      r_write_ack    <= 1'b0;
      r_read_ack     <= 1'b0;
      r_refresh_pend <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_aref_ack     <= w_aref_grant;
      r_write_ack    <= w_write_grant;
      r_read_ack     <= w_read_grant;
      // drop the hint once the refresh owns the bus, even if req lingers a cycle
      r_refresh_pend <= aref_req & ~w_aref_grant & ~r_aref_ack;
    end
  end

  assign aref_ack     = r_aref_ack;
  assign write_ack    = r_write_ack;
  assign read_ack     = r_read_ack;
  assign refresh_pend = r_refresh_pend;
  assign sdram_cke    = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
  assign sdram_addr   = w_addr;
  assign sdram_ba     = w_ba;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sdram_arbit                                                |
// | Purpose  : Self-checking bench for sdram_arbit (SDRAM_ARBIT_RR_EN aware) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sdram_arbit;
  localparam int AW = 13;
  localparam int BW = 2;
  localparam int PW = 1 + 4 + AW + BW;
  localparam logic [PW-1:0] NOP_PINS = {1'b1, 4'b0111, {AW{1'b0}}, {BW{1'b0}}};

  logic          sysclk_100M = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_end, aref_req, aref_end, write_req, write_prech_end, read_req, read_prech_end;
  logic [3:0]    init_cmd, aref_cmd, write_cmd, read_cmd;
  logic [AW-1:0] init_addr, aref_addr, write_addr, read_addr;
  logic [BW-1:0] init_bank, aref_bank, write_bank, read_bank;
  logic          aref_ack, write_ack, read_ack, refresh_pend;
  logic          sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [AW-1:0] sdram_addr;
  logic [BW-1:0] sdram_ba;
  logic [2:0]    acks;
  logic [PW-1:0] pins;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sysclk_100M = ~sysclk_100M;

  sdram_arbit #(.ADDR_W(AW), .BANK_W(BW), .CMD_NOP(4'b0111)) dut (
    .sysclk_100M(sysclk_100M), .rst_n(rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_bank(init_bank),
    .aref_req(aref_req), .aref_ack(aref_ack), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_bank(aref_bank),
    .write_req(write_req), .write_ack(write_ack), .write_prech_end(write_prech_end),
    .write_cmd(write_cmd), .write_addr(write_addr), .write_bank(write_bank),
    .read_req(read_req), .read_ack(read_ack), .read_prech_end(read_prech_end),
    .read_cmd(read_cmd), .read_addr(read_addr), .read_bank(read_bank),
    .refresh_pend(refresh_pend), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
  );

  assign acks = {aref_ack, write_ack, read_ack};
  assign pins = {sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_addr, sdram_ba};

  // Reference model: who owns the bus (0 init, 1 idle/arbitrating, 2 refresh, 3 write, 4 read)
  int         m_own;
  logic [2:0] m_ack;
  logic       m_pend;
  logic       m_last_rd;
  logic       m_pick_w;

`ifdef SDRAM_ARBIT_RR_EN
  assign m_pick_w = write_req && (!read_req || m_last_rd);
`else
  assign m_pick_w = write_req;
`endif

  always @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      m_own <= 0; m_ack <= 3'b000; m_pend <= 1'b0; m_last_rd <= 1'b1;
    end else begin
      m_ack  <= 3'b000;
      m_pend <= aref_req && !m_ack[2] && !(m_own == 1 && aref_req);
      case (m_own)
        0: if (init_end) m_own <= 1;
        1: if (aref_req) begin
             m_own <= 2; m_ack <= 3'b100;
           end else if (write_req || read_req) begin
             if (m_pick_w) begin m_own <= 3; m_ack <= 3'b010; m_last_rd <= 1'b0; end
             else          begin m_own <= 4; m_ack <= 3'b001; m_last_rd <= 1'b1; end
           end
        2: if (aref_end) m_own <= 1;
        3: if (write_prech_end) m_own <= 1;
        4: if (read_prech_end) m_own <= 1;
        default: m_own <= 1;
      endcase
    end
  end

  function automatic logic [PW-1:0] pk(input logic [3:0] c, input logic [AW-1:0] a, input logic [BW-1:0] b);
    return {1'b1, c, a, b};
  endfunction

  function automatic logic [PW-1:0] exp_pins();
    case (m_own)
      0:       return pk(init_cmd, init_addr, init_bank);
      2:       return pk(aref_cmd, aref_addr, aref_bank);
      3:       return pk(write_cmd, write_addr, write_bank);
      4:       return pk(read_cmd, read_addr, read_bank);
      default: return NOP_PINS;
    endcase
  endfunction

  task automatic cyc();
    @(negedge sysclk_100M);
  endtask

  task automatic rand_buses();
    init_cmd  = 4'($urandom); init_addr  = AW'($urandom); init_bank  = BW'($urandom);
    aref_cmd  = 4'($urandom); aref_addr  = AW'($urandom); aref_bank  = BW'($urandom);
    write_cmd = 4'($urandom); write_addr = AW'($urandom); write_bank = BW'($urandom);
    read_cmd  = 4'($urandom); read_addr  = AW'($urandom); read_bank  = BW'($urandom);
  endtask

  task automatic idle_inputs();
    init_end = 0; aref_req = 0; aref_end = 0; write_req = 0; write_prech_end = 0;
    read_req = 0; read_prech_end = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rand_buses(); rst_n = 0;
    cyc(); #1;
    n_checks++; if (acks !== 3'b000) begin n_errors++; $display("FAIL reset_acks: got %b expected 000", acks); end
    n_checks++; if (refresh_pend !== 1'b0) begin n_errors++; $display("FAIL reset_pend: got %b expected 0", refresh_pend); end
    n_checks++; if (sdram_cke !== 1'b1) begin n_errors++; $display("FAIL reset_cke: got %b expected 1", sdram_cke); end
    n_checks++; if (pins !== pk(init_cmd, init_addr, init_bank)) begin
      n_errors++; $display("FAIL reset_pins: got %h expected %h", pins, pk(init_cmd, init_addr, init_bank)); end
    cyc(); rst_n = 1;
  endtask

  task automatic test_init_hold();
    for (int i = 0; i < 200; i++) begin
      cyc(); init_end = 0; write_req = 1; rand_buses(); #1;
      n_checks++; if (write_ack !== 1'b0) begin n_errors++; $display("FAIL init_hold_ack cyc %0d: got %b expected 0", i, write_ack); end
      n_checks++; if (pins !== pk(init_cmd, init_addr, init_bank)) begin
        n_errors++; $display("FAIL init_hold_pins cyc %0d: got %h expected %h", i, pins, pk(init_cmd, init_addr, init_bank)); end
    end
    cyc(); init_end = 1; #1;
    n_checks++; if (pins !== pk(init_cmd, init_addr, init_bank)) begin
      n_errors++; $display("FAIL init_end_pins: got %h expected %h", pins, pk(init_cmd, init_addr, init_bank)); end
    cyc(); init_end = 0; #1;
    n_checks++; if (pins !== NOP_PINS || acks !== 3'b000) begin
      n_errors++; $display("FAIL arbit_entry: got pins %h acks %b expected %h 000", pins, acks, NOP_PINS); end
    cyc(); #1;
    n_checks++; if (acks !== 3'b010 || pins !== pk(write_cmd, write_addr, write_bank)) begin
      n_errors++; $display("FAIL first_write_grant: got acks %b pins %h expected 010 %h", acks, pins, pk(write_cmd, write_addr, write_bank)); end
    write_req = 0;
    cyc(); write_prech_end = 1; #1;
    n_checks++; if (acks !== 3'b000) begin n_errors++; $display("FAIL ack_one_cycle: got %b expected 000", acks); end
    cyc(); write_prech_end = 0; #1;
    n_checks++; if (pins !== NOP_PINS) begin n_errors++; $display("FAIL write_release: got %h expected %h", pins, NOP_PINS); end
  endtask

  task automatic test_priority();
    cyc(); aref_req = 1; write_req = 1; #1;
    n_checks++; if (pins !== NOP_PINS || refresh_pend !== 1'b0) begin
      n_errors++; $display("FAIL prio_pre: got pins %h pend %b expected %h 0", pins, refresh_pend, NOP_PINS); end
    cyc(); #1;
    n_checks++; if (acks !== 3'b100 || refresh_pend !== 1'b0) begin
      n_errors++; $display("FAIL prio_aref_ack: got acks %b pend %b expected 100 0", acks, refresh_pend); end
    n_checks++; if (pins !== pk(aref_cmd, aref_addr, aref_bank)) begin
      n_errors++; $display("FAIL prio_aref_pins: got %h expected %h", pins, pk(aref_cmd, aref_addr, aref_bank)); end
    aref_req = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); rand_buses(); #1;
      n_checks++; if (acks !== 3'b000 || pins !== pk(aref_cmd, aref_addr, aref_bank)) begin
        n_errors++; $display("FAIL aref_hold cyc %0d: got acks %b pins %h expected 000 %h", i, acks, pins, pk(aref_cmd, aref_addr, aref_bank)); end
    end
    cyc(); aref_end = 1; #1;
    cyc(); aref_end = 0; #1;
    n_checks++; if (pins !== NOP_PINS || acks !== 3'b000) begin
      n_errors++; $display("FAIL aref_gap: got pins %h acks %b expected %h 000", pins, acks, NOP_PINS); end
    cyc(); #1;
    n_checks++; if (acks !== 3'b010) begin n_errors++; $display("FAIL write_after_aref: got %b expected 010", acks); end
    write_req = 0;
  endtask

  task automatic test_write_cmd();
    cyc(); write_cmd = 4'b0011; write_addr = 13'h0A5; write_bank = 2'd1; #1;
    n_checks++; if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== 4'b0011 || sdram_addr !== 13'h0A5 || sdram_ba !== 2'd1) begin
      n_errors++; $display("FAIL write_cmd_pins: got cmd %b addr %h ba %0d expected 0011 0a5 1",
        {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, sdram_addr, sdram_ba); end
  endtask

  task automatic test_refresh_pend();
    cyc(); aref_req = 1; #1;
    n_checks++; if (refresh_pend !== 1'b0) begin n_errors++; $display("FAIL pend_latency: got %b expected 0", refresh_pend); end
    cyc(); #1;
    n_checks++; if (refresh_pend !== 1'b1 || acks !== 3'b000 || pins !== pk(write_cmd, write_addr, write_bank)) begin
      n_errors++; $display("FAIL pend_no_preempt: got pend %b acks %b pins %h expected 1 000 %h",
        refresh_pend, acks, pins, pk(write_cmd, write_addr, write_bank)); end
    cyc(); write_prech_end = 1; #1;
    cyc(); write_prech_end = 0; #1;
    n_checks++; if (pins !== NOP_PINS || acks !== 3'b000 || refresh_pend !== 1'b1) begin
      n_errors++; $display("FAIL pend_gap: got pins %h acks %b pend %b expected %h 000 1", pins, acks, refresh_pend, NOP_PINS); end
    cyc(); #1;
    n_checks++; if (acks !== 3'b100 || refresh_pend !== 1'b0) begin
      n_errors++; $display("FAIL pend_aref_grant: got acks %b pend %b expected 100 0", acks, refresh_pend); end
    aref_req = 0;
    cyc(); aref_end = 1;
    cyc(); aref_end = 0;
  endtask

  task automatic test_back_to_back();
    int g[6];
    int ngr = 0;
    int own = 0;
    int hold = 0;
    cyc(); rst_n = 0; cyc(); rst_n = 1; cyc(); init_end = 1; cyc(); init_end = 0;
    write_req = 1; read_req = 1;
    for (int c = 0; c < 200 && ngr < 6; c++) begin
      cyc(); write_prech_end = 0; read_prech_end = 0; #1;
      if (write_ack || read_ack) begin
        g[ngr] = write_ack ? 1 : 2; own = g[ngr]; ngr++; hold = 0;
      end else if (own != 0) begin
        hold++;
        if (hold == 2) begin
          if (own == 1) write_prech_end = 1; else read_prech_end = 1;
          own = 0;
        end
      end
    end
    n_checks++; if (ngr != 6) begin n_errors++; $display("FAIL b2b_timeout: got %0d grants expected 6", ngr); end
    for (int i = 0; i < ngr; i++) begin
`ifdef SDRAM_ARBIT_RR_EN
      n_checks++; if (g[i] != ((i % 2 == 0) ? 1 : 2)) begin
        n_errors++; $display("FAIL b2b_rr grant %0d: got %0d expected %0d (1=W 2=R)", i, g[i], (i % 2 == 0) ? 1 : 2); end
`else
      n_checks++; if (g[i] != 1) begin
        n_errors++; $display("FAIL b2b_fixed grant %0d: got %0d expected 1 (1=W 2=R)", i, g[i]); end
`endif
    end
    write_req = 0; read_req = 0;
    cyc(); write_prech_end = 1; read_prech_end = 1;
    cyc(); write_prech_end = 0; read_prech_end = 0;
  endtask

  task automatic test_reset_mid_read();
    cyc(); read_req = 1; #1;
    cyc(); #1;
    n_checks++; if (acks !== 3'b001 || pins !== pk(read_cmd, read_addr, read_bank)) begin
      n_errors++; $display("FAIL read_grant: got acks %b pins %h expected 001 %h", acks, pins, pk(read_cmd, read_addr, read_bank)); end
    read_req = 0;
    cyc(); rand_buses();
    cyc(); rst_n = 0; write_req = 1; #1;
    n_checks++; if (acks !== 3'b000 || refresh_pend !== 1'b0 || pins !== pk(init_cmd, init_addr, init_bank)) begin
      n_errors++; $display("FAIL mid_read_reset: got acks %b pend %b pins %h expected 000 0 %h",
        acks, refresh_pend, pins, pk(init_cmd, init_addr, init_bank)); end
    cyc(); rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(); rand_buses(); #1;
      n_checks++; if (acks !== 3'b000 || pins !== pk(init_cmd, init_addr, init_bank)) begin
        n_errors++; $display("FAIL reinit_hold cyc %0d: got acks %b pins %h expected 000 %h", i, acks, pins, pk(init_cmd, init_addr, init_bank)); end
    end
    cyc(); init_end = 1; cyc(); init_end = 0; #1;
    n_checks++; if (pins !== NOP_PINS) begin n_errors++; $display("FAIL reinit_arbit: got %h expected %h", pins, NOP_PINS); end
    cyc(); #1;
    n_checks++; if (acks !== 3'b010) begin n_errors++; $display("FAIL reinit_write_ack: got %b expected 010", acks); end
    write_req = 0;
    cyc(); write_prech_end = 1; cyc(); write_prech_end = 0;
  endtask

  task automatic test_random();
    cyc(); rst_n = 0; idle_inputs(); cyc(); rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n           = ($urandom_range(0, 199) != 0);
      init_end        = ($urandom_range(0, 5) == 0);
      aref_req        = ($urandom_range(0, 5) == 0);
      write_req       = ($urandom_range(0, 2) == 0);
      read_req        = ($urandom_range(0, 2) == 0);
      aref_end        = ($urandom_range(0, 4) == 0);
      write_prech_end = ($urandom_range(0, 4) == 0);
      read_prech_end  = ($urandom_range(0, 4) == 0);
      rand_buses();
      #1;
      n_checks++; if (acks !== m_ack) begin n_errors++; $display("FAIL rand_acks cyc %0d: got %b expected %b", i, acks, m_ack); end
      n_checks++; if (refresh_pend !== m_pend) begin n_errors++; $display("FAIL rand_pend cyc %0d: got %b expected %b", i, refresh_pend, m_pend); end
      n_checks++; if (pins !== exp_pins()) begin n_errors++; $display("FAIL rand_pins cyc %0d: got %h expected %h", i, pins, exp_pins()); end
    end
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_hold();
    test_priority();
    test_write_cmd();
    test_refresh_pend();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
